mod_n_t_counter: RTL and testbench
==================================

MOD_N_T_COUNTER -- requirements
Module: mod_n_t_counter

Interface
REQ-001 Parameter: WIDTH, default 4, counter width in bits (valid 2..16).
REQ-002 Parameter: MAX_VAL, default 9, terminal count value; SHALL satisfy 1 <= MAX_VAL <= 2^WIDTH-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  count enable.
REQ-006 up  input  1  direction: 1 = count up, 0 = count down.
REQ-007 load  input  1  synchronous parallel load strobe.
REQ-008 d  input  WIDTH  parallel load value.
REQ-009 q  output  WIDTH  registered count.
REQ-010 qb  output  WIDTH  bitwise complement of q, always.
REQ-011 tc  output  1  terminal-count flag, combinational.
REQ-012 wrap  output  1  registered one-cycle pulse, asserted the cycle after a wrap occurs.

Function
REQ-013 Each bit of q SHALL be a T-type stage: the bit inverts when its toggle term is 1 at the clock edge and holds otherwise.
REQ-014 Up-count toggle term: bit 0 toggles when en=1; bit i (i>0) toggles when en=1 and q[i-1:0] are all 1.
REQ-015 Down-count toggle term: bit 0 toggles when en=1; bit i (i>0) toggles when en=1 and q[i-1:0] are all 0.
REQ-016 Modulus override, up: en=1, up=1, q==MAX_VAL -> next q = 0, overriding REQ-014.
REQ-017 Modulus override, down: en=1, up=0, q==0 -> next q = MAX_VAL, overriding REQ-015.
REQ-018 Out-of-range recovery: if q > MAX_VAL with en=1, next q SHALL be 0 for both directions.
REQ-019 Priority at a clock edge: load > en; load=1 SHALL load d regardless of en and up.
REQ-020 Load clamp: d > MAX_VAL SHALL load MAX_VAL; otherwise load d exactly.
REQ-021 en=0 and load=0 -> q holds; wrap deasserts.
REQ-022 tc = en & ((up & q==MAX_VAL) | (~up & q==0)); it SHALL follow up/en changes within the same cycle.
REQ-023 wrap SHALL be 1 for exactly one cycle after an edge at which REQ-016 or REQ-017 applied. It SHALL be 0 after load edges, out-of-range recovery edges and hold edges.
REQ-024 Latency: one clock from en/load sampled to q update; no pipeline beyond q and wrap registers.
REQ-025 Direction change mid-count SHALL take effect at the next edge with no lost or extra step.

Reset
REQ-026 rst=1 SHALL asynchronously force q=0 (qb all 1) and wrap=0 without waiting for clk.
REQ-027 tc during reset SHALL follow REQ-022 with q=0; it is 1 only when en=1 and up=0.
REQ-028 Release of rst SHALL be clean: the first count edge after deassertion advances from 0.
REQ-029 Reset asserted mid-count or mid-load SHALL discard the pending update.

Verification (WIDTH=4, MAX_VAL=9)
REQ-030 Reset check: assert rst between clock edges with q=6 -> q=0, qb=4'b1111, wrap=0 immediately.
REQ-031 Up wrap: en=1, up=1 from 0 for 11 edges -> q steps 1..9, then 0, then 1. tc=1 while q=9. wrap=1 only in the cycle after the 9->0 edge.
REQ-032 Down wrap: en=1, up=0 from 2 -> q steps 1, 0, 9, 8. tc=1 while q=0. wrap pulses once after the 0->9 edge.
REQ-033 Load priority/clamp: load=1, en=1, d=4'd13 -> q=9, wrap=0. Then load=1, d=4'd3 -> q=3.
REQ-034 Hold and direction flip: q=5 with en=0 for 3 edges -> q stays 5. Then en=1, up toggling 1,0,1 -> q=6, 5, 6.
REQ-035 Out-of-range recovery: force q=4'd12 via hierarchical deposit, then en=1 -> q=0 and wrap=0.

Source files
------------

// File: rtl/mod_n_t_counter.sv
// Modulo-N up/down counter built from T-type stages.
// Supports terminal-count flag, wrap pulse and clamped parallel load.
module mod_n_t_counter #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_load_val;
  logic             w_wrap_nxt;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_oor;

  assign w_at_max   = (r_q == LP_MAX);
  assign w_at_zero  = (r_q == '0);
  assign w_oor      = (r_q > LP_MAX);
  assign w_load_val = (d > LP_MAX) ? LP_MAX : d;

  // Ripple toggle terms: all-ones prefix for up, all-zeros prefix for down
  always_comb begin : toggle_terms
    logic v_ones;
    logic v_zeros;
    v_ones  = 1'b1;
    v_zeros = 1'b1;
    w_t     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_t[i]  = en & (up ? v_ones : v_zeros);
      v_ones  = v_ones & r_q[i];
      v_zeros = v_zeros & ~r_q[i];
    end
  end

  always_comb begin
    w_q_nxt    = r_q;
    w_wrap_nxt = 1'b0;
    if (load) begin
      w_q_nxt = w_load_val;
    end else if (en) begin
      if (w_oor) begin
        w_q_nxt = '0;
      end else if (up && w_at_max) begin
        w_q_nxt    = '0;
        w_wrap_nxt = 1'b1;
      end else if (!up && w_at_zero) begin
        w_q_nxt    = LP_MAX;
        w_wrap_nxt = 1'b1;
      end else begin
        w_q_nxt = r_q ^ w_t;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign q    = r_q;
  assign qb   = ~r_q;
  assign wrap = r_wrap;
  assign tc   = en & ((up & w_at_max) | (~up & w_at_zero));

endmodule

// File: tb/tb_mod_n_t_counter.sv
// Directed and randomized checks of mod_n_t_counter against an
// arithmetic reference model.
module tb_mod_n_t_counter;

  localparam int W   = 4;
  localparam int MAX = 9;

  logic         clk;
  logic         rst;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic [W-1:0] qb;
  logic         tc;
  logic         wrap;

  int total;
  int passed;
  int m_q;
  int m_wrap;

  mod_n_t_counter #(.WIDTH(W), .MAX_VAL(MAX)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .up   (up),
    .load (load),
    .d    (d),
    .q    (q),
    .qb   (qb),
    .tc   (tc),
    .wrap (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int exp_tc();
    if (!en) return 0;
    if (up && m_q == MAX) return 1;
    if (!up && m_q == 0) return 1;
    return 0;
  endfunction

  // Behaviour at one rising edge, in plain arithmetic
  task automatic model_step();
    int dv;
    dv = int'(d);
    m_wrap = 0;
    if (load) begin
      m_q = (dv > MAX) ? MAX : dv;
    end else if (en) begin
      if (m_q > MAX) begin
        m_q = 0;
      end else if (up) begin
        if (m_q == MAX) begin
          m_q = 0;
          m_wrap = 1;
        end else begin
          m_q = m_q + 1;
        end
      end else begin
        if (m_q == 0) begin
          m_q = MAX;
          m_wrap = 1;
        end else begin
          m_q = m_q - 1;
        end
      end
    end
  endtask

  task automatic tick(input string tag);
    #1;
    check({tag, ".tc"}, int'(tc), exp_tc());
    model_step();
    @(posedge clk);
    #1;
    check({tag, ".q"}, int'(q), m_q);
    check({tag, ".qb"}, int'(qb), (~m_q) & 15);
    check({tag, ".wrap"}, int'(wrap), m_wrap);
  endtask

  task automatic drive(input logic e, input logic u,
                       input logic l, input logic [W-1:0] dv);
    en   = e;
    up   = u;
    load = l;
    d    = dv;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    m_q    = 0;
    m_wrap = 0;
    rst    = 1'b1;
    drive(1'b0, 1'b1, 1'b0, '0);

    // reset state and tc while held in reset
    repeat (2) @(posedge clk);
    #1;
    check("rst.q", int'(q), 0);
    check("rst.qb", int'(qb), 15);
    check("rst.wrap", int'(wrap), 0);
    check("rst.tc_idle", int'(tc), 0);
    drive(1'b1, 1'b0, 1'b0, '0);
    #1;
    check("rst.tc_down", int'(tc), 1);
    drive(1'b1, 1'b1, 1'b0, '0);
    #1;
    check("rst.tc_up", int'(tc), 0);
    drive(1'b0, 1'b1, 1'b0, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // up wrap: 1..9, 0, 1
    drive(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 11; i++) tick("upwrap");

    // down wrap from 2: 1, 0, 9, 8
    drive(1'b0, 1'b0, 1'b1, 4'd2);
    tick("ld2");
    drive(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) tick("dnwrap");

    // load priority and clamp
    drive(1'b1, 1'b1, 1'b1, 4'd13);
    tick("ldclamp");
    check("ldclamp.q9", int'(q), 9);
    drive(1'b1, 1'b0, 1'b1, 4'd3);
    tick("ld3");
    check("ld3.q3", int'(q), 3);

    // hold then direction flips
    drive(1'b0, 1'b1, 1'b1, 4'd5);
    tick("ld5");
    drive(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) tick("hold");
    drive(1'b1, 1'b1, 1'b0, '0);
    tick("flip_u");
    up = 1'b0;
    tick("flip_d");
    up = 1'b1;
    tick("flip_u2");
    check("flip.q6", int'(q), 6);

    // async reset mid-count from q=6 discards the pending step
    drive(1'b0, 1'b1, 1'b1, 4'd6);
    tick("ld6");
    drive(1'b1, 1'b1, 1'b0, '0);
    #2;
    rst = 1'b1;
    #1;
    check("arst.q", int'(q), 0);
    check("arst.qb", int'(qb), 15);
    check("arst.wrap", int'(wrap), 0);
    @(posedge clk);
    #1;
    check("arst.hold", int'(q), 0);
    rst = 1'b0;
    m_q = 0;
    m_wrap = 0;
    tick("post_rst");

    // reset clears a live wrap pulse
    drive(1'b0, 1'b1, 1'b1, 4'd9);
    tick("ld9");
    drive(1'b1, 1'b1, 1'b0, '0);
    tick("wrap_pre");
    #2;
    rst = 1'b1;
    #1;
    check("arst2.wrap", int'(wrap), 0);
    check("arst2.q", int'(q), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_q = 0;
    m_wrap = 0;

    // out-of-range recovery
    drive(1'b0, 1'b1, 1'b0, '0);
    force dut.r_q = 4'd12;
    #1;
    release dut.r_q;
    #1;
    check("oor.seed", int'(q), 12);
    m_q = 12;
    drive(1'b1, 1'b0, 1'b0, '0);
    tick("oor");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
      tick("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
